rsa_uart_sequencer: RTL



---
 rtl/rsa_uart_sequencer_if.sv | 32 +++
 rtl/rsa_uart_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rsa_uart_sequencer_if.sv
// Bundle of UART byte-stream and RSA-core signals between the sequencer (slave)
// and its environment (master).
interface rsa_uart_sequencer_if #(
    parameter int N = 32
);
    // Handshakes are strobes, not valid/ready: rx_valid, tx_valid, core_start and
    // core_done are each high for exactly one cycle per transfer and data is only
    // meaningful in that cycle; is_transmitting is the sole back-pressure signal.
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         is_transmitting;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic [N-1:0] msg_out;
    logic [N-1:0] exp_out;
    logic [N-1:0] mod_out;
    logic         core_start;
    logic         core_done;
    logic [N-1:0] core_result;
    logic         busy;
    logic         cmd_error;

    modport master (
        output rx_valid, rx_byte, is_transmitting, core_done, core_result,
        input  tx_valid, tx_byte, msg_out, exp_out, mod_out, core_start, busy, cmd_error
    );

    modport slave (
        input  rx_valid, rx_byte, is_transmitting, core_done, core_result,
        output tx_valid, tx_byte, msg_out, exp_out, mod_out, core_start, busy, cmd_error
    );
endinterface

// File: rtl/rsa_uart_sequencer.sv
// UART command sequencer for the RSA core: loads operands MSB-first, runs the core and
// streams the result back bytewise. Define RSA_SEQ_ACK_EN to acknowledge each operand load.
module rsa_uart_sequencer #(
    parameter int N          = 32,
    parameter int BYTE_CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    rsa_uart_sequencer_if.slave  bus,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_TX_BYTE,
`ifdef RSA_SEQ_ACK_EN
        S_TX_GAP,
        S_ACK
`else
        S_TX_GAP
`endif
    } state_t;

    localparam logic [BYTE_CNT_W-1:0] BYTES_LAST = BYTE_CNT_W'(N / 8 - 1);
    localparam logic [BYTE_CNT_W-1:0] BYTES_ALL  = BYTE_CNT_W'(N / 8);
    localparam logic [BYTE_CNT_W-1:0] CNT_ONE    = BYTE_CNT_W'(1);

    state_t                state_q, state_d;
    logic [N-1:0]          msg_q, msg_d;
    logic [N-1:0]          exp_q, exp_d;
    logic [N-1:0]          mod_q, mod_d;
    logic [N-1:0]          result_q, result_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            sel_q, sel_d;
    logic                  cmd_error_q, cmd_error_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            msg_q       <= '0;
            exp_q       <= '0;
            mod_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            exp_q       <= exp_d;
            mod_q       <= mod_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == 8'h01 || bus.rx_byte == 8'h02 || bus.rx_byte == 8'h03)
                        state_d = S_LOAD;
                    else if (bus.rx_byte == 8'h04)
                        state_d = S_START;
                end
            end
            S_LOAD: begin
                if (bus.rx_valid && cnt_q == BYTES_LAST) begin
`ifdef RSA_SEQ_ACK_EN
                    state_d = S_ACK;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_START:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.core_done) state_d = S_TX_BYTE;
            S_TX_BYTE:   if (!bus.is_transmitting) state_d = S_TX_GAP;
            S_TX_GAP:    state_d = (cnt_q == BYTES_ALL) ? S_IDLE : S_TX_BYTE;
`ifdef RSA_SEQ_ACK_EN
            S_ACK:       if (!bus.is_transmitting) state_d = S_IDLE;
`endif
            default:     state_d = S_IDLE;
        endcase
    end

    // Datapath updates; bytes and core_done arriving in other states fall through the case.
    always_comb begin
        msg_d       = msg_q;
        exp_d       = exp_q;
        mod_d       = mod_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        cmd_error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == 8'h01 || bus.rx_byte == 8'h02 || bus.rx_byte == 8'h03) begin
                        sel_d = bus.rx_byte[1:0];
                        cnt_d = '0;
                    end else if (bus.rx_byte != 8'h04) begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.rx_valid) begin
                    case (sel_q)
                        2'd1:    msg_d = {msg_q[N-9:0], bus.rx_byte};
                        2'd2:    exp_d = {exp_q[N-9:0], bus.rx_byte};
                        2'd3:    mod_d = {mod_q[N-9:0], bus.rx_byte};
                        default: ;
                    endcase
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.core_done) begin
                    result_d = bus.core_result;
                    cnt_d    = '0;
                end
            end
            S_TX_BYTE: begin
                if (!bus.is_transmitting) begin
                    result_d = {result_q[N-9:0], 8'h00};
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_byte  = 8'h00;
        if (state_q == S_TX_BYTE && !bus.is_transmitting) begin
            bus.tx_valid = 1'b1;
            bus.tx_byte  = result_q[N-1:N-8];
        end
`ifdef RSA_SEQ_ACK_EN
        if (state_q == S_ACK && !bus.is_transmitting) begin
            bus.tx_valid = 1'b1;
            bus.tx_byte  = {6'b101000, sel_q};
        end
`endif
        bus.core_start = (state_q == S_START);
        bus.busy       = (state_q != S_IDLE) && (state_q != S_LOAD);
        bus.cmd_error  = cmd_error_q;
        bus.msg_out    = msg_q;
        bus.exp_out    = exp_q;
        bus.mod_out    = mod_q;
        state_dbg      = state_q;
    end
endmodule
